// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-master DRAM arbiter.
package dram_arb_pkg;

    // Default widths of the request register; the arbiter's ADDR_W/DATA_W
    // parameters default to these so the struct fields line up with the ports.
    localparam int DRAM_ADDR_W = 18;
    localparam int DRAM_DATA_W = 32;

    // Access-size encodings understood by dram_driver. 2'b11 is passed through.
    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Latched winning request; id names the master that owns it.
    typedef struct packed {
        logic                   we;
        logic [DRAM_ADDR_W-1:0] addr;
        logic [DRAM_DATA_W-1:0] wdata;
        logic [1:0]             mask;
        logic                   id;
    } dram_req_t;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the master that did not win last
// time gets the grant. Purely combinational; the caller owns the 'last' flop.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       id
);

    // Pick a winner only when enabled; a tie goes to the opposite of 'last'.
    always_comb begin
        gnt = 2'b00;
        id  = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                id  = ~last;
                gnt = last ? 2'b01 : 2'b10;
            end else if (req0) begin
                id  = 1'b0;
                gnt = 2'b01;
            end else if (req1) begin
                id  = 1'b1;
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master arbiter/sequencer in front of dram_driver. Grants one request,
// drives it to the DRAM port for exactly one ACCESS cycle, then returns a
// registered done pulse with the captured read data in RESP. RESP can grant
// the next request, giving one access every two cycles under load.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [1:0]        m0_mask,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [1:0]        m1_mask,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] perip_addr,
    output logic [DATA_W-1:0] perip_wdata,
    output logic [1:0]        perip_mask,
    output logic              dram_wen,
    input  logic [DATA_W-1:0] perip_rdata
);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    dram_req_t         req_q, req_d;
    logic [1:0]        done_q, done_d;
    logic              dram_wen_q, dram_wen_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              arb_en;
    logic [1:0]        arb_gnt;
    logic              arb_id;
    dram_req_t         win_req;

    // Arbitrate only in IDLE/RESP, and never while reset is held.
    assign arb_en = ((state_q == IDLE) || (state_q == RESP)) && !rst;

    rr_arb2 u_rr_arb2 (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (last_q),
        .en   (arb_en),
        .gnt  (arb_gnt),
        .id   (arb_id)
    );

    // Select the winning master's request fields for capture.
    always_comb begin
        win_req       = '0;
        win_req.id    = arb_id;
        win_req.we    = arb_id ? m1_we    : m0_we;
        win_req.addr  = arb_id ? m1_addr  : m0_addr;
        win_req.wdata = arb_id ? m1_wdata : m0_wdata;
        win_req.mask  = arb_id ? m1_mask  : m0_mask;
    end

    // Next-state logic: grant in IDLE/RESP, single DRAM cycle in ACCESS,
    // completion pulse and read-data capture on the way into RESP.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        req_d      = req_q;
        done_d     = 2'b00;
        dram_wen_d = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (arb_gnt != 2'b00) begin
                    req_d      = win_req;
                    last_d     = arb_id;
                    dram_wen_d = win_req.we;
                    state_d    = ACCESS;
                end else begin
                    state_d    = IDLE;
                end
            end
            ACCESS: begin
                // Stores capture too; only done qualifies the value.
                if (req_q.id) m1_rdata_d = perip_rdata;
                else          m0_rdata_d = perip_rdata;
                done_d[req_q.id] = 1'b1;
                state_d          = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything at once so a
    // write in progress loses its enable immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            req_q      <= '0;
            done_q     <= 2'b00;
            dram_wen_q <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            req_q      <= req_d;
            done_q     <= done_d;
            dram_wen_q <= dram_wen_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_gnt      = arb_gnt[0];
    assign m1_gnt      = arb_gnt[1];
    assign m0_done     = done_q[0];
    assign m1_done     = done_q[1];
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign perip_addr  = req_q.addr;
    assign perip_wdata = req_q.wdata;
    assign perip_mask  = req_q.mask;
    assign dram_wen    = dram_wen_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small behavioural DRAM model.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int AW = 18;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [1:0]    m0_mask, m1_mask;
    logic          m0_gnt, m0_done, m1_gnt, m1_done;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] perip_addr;
    logic [DW-1:0] perip_wdata, perip_rdata;
    logic [1:0]    perip_mask;
    logic          dram_wen;

    logic [31:0]   mem [0:63];
    logic [31:0]   rd_word;
    logic          pl_en = 1'b0;
    logic [5:0]    pl_idx;
    logic [31:0]   pl_data;
    int            wen_cnt = 0;

    int            n_chk = 0;
    int            n_fail = 0;
    int            w0, ngnt;
    logic          p0, p1;
    logic [1:0]    exp_g;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .perip_addr(perip_addr), .perip_wdata(perip_wdata), .perip_mask(perip_mask),
        .dram_wen(dram_wen), .perip_rdata(perip_rdata)
    );

    always #5 clk = ~clk;

    // DRAM model read path: combinational, sub-word zero-extended.
    always_comb begin
        rd_word = mem[perip_addr[7:2]];
        case (perip_mask)
            MASK_B:  perip_rdata = (rd_word >> (8 * perip_addr[1:0])) & 32'h0000_00FF;
            MASK_H:  perip_rdata = (rd_word >> (16 * perip_addr[1])) & 32'h0000_FFFF;
            default: perip_rdata = rd_word;
        endcase
    end

    // DRAM model write path and bench preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (dram_wen) begin
            wen_cnt <= wen_cnt + 1;
            case (perip_mask)
                MASK_B:  mem[perip_addr[7:2]][8*perip_addr[1:0] +: 8] <= perip_wdata[7:0];
                MASK_H:  mem[perip_addr[7:2]][16*perip_addr[1] +: 16] <= perip_wdata[15:0];
                default: mem[perip_addr[7:2]] <= perip_wdata;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        step();
        pl_en   = 1'b0;
    endtask

    task automatic set_m0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; m0_mask = m;
    endtask

    task automatic set_m1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; m1_mask = m;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_mask = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_mask = '0;
        pl_idx = '0; pl_data = '0;
        @(negedge clk);
        preload(6'd4, 32'h1122_3344);
        preload(6'd5, 32'h5566_7788);

        // Reset values, and no grant while reset is held.
        chk("rst_addr",   32'(perip_addr), 32'h0);
        chk("rst_wdata",  perip_wdata, 32'h0);
        chk("rst_mask",   32'(perip_mask), 32'h0);
        chk("rst_wen",    32'(dram_wen), 32'h0);
        chk("rst_done",   32'({m1_done, m0_done}), 32'h0);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata, 32'h0);
        set_m0(1'b0, 18'h10, 32'h0, MASK_W);
        #1 chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
        m0_req = 1'b0;
        step();
        rst = 1'b0;

        // Single word load from m0.
        w0 = wen_cnt;
        set_m0(1'b0, 18'h10, 32'h0, MASK_W);
        #1 chk("t1_gnt", 32'({m1_gnt, m0_gnt}), 32'h1);
        step();
        m0_req = 1'b0;
        chk("t1_paddr", 32'(perip_addr), 32'h10);
        chk("t1_wen",   32'(dram_wen), 32'h0);
        chk("t1_early_done", 32'(m0_done), 32'h0);
        step();
        chk("t1_done",  32'({m1_done, m0_done}), 32'h1);
        chk("t1_rdata", m0_rdata, 32'h1122_3344);
        step();
        chk("t1_done_off", 32'(m0_done), 32'h0);
        chk("t1_no_wen",   32'(wen_cnt - w0), 32'h0);

        // m1 byte store, then word load granted from RESP.
        w0 = wen_cnt;
        set_m1(1'b1, 18'h13, 32'h0000_00AB, MASK_B);
        #1 chk("t2_gnt", 32'({m1_gnt, m0_gnt}), 32'h2);
        step();
        m1_req = 1'b0;
        chk("t2_wen",   32'(dram_wen), 32'h1);
        chk("t2_pmask", 32'(perip_mask), 32'(MASK_B));
        chk("t2_pwdata", perip_wdata, 32'hAB);
        step();
        chk("t2_st_done", 32'({m1_done, m0_done}), 32'h2);
        set_m1(1'b0, 18'h10, 32'h0, MASK_W);
        #1 chk("t2_resp_gnt", 32'(m1_gnt), 32'h1);
        step();
        m1_req = 1'b0;
        chk("t2_ld_wen", 32'(dram_wen), 32'h0);
        step();
        chk("t2_ld_done", 32'(m1_done), 32'h1);
        chk("t2_rdata",   m1_rdata, 32'hAB22_3344);
        chk("t2_m0_hold", m0_rdata, 32'h1122_3344);
        chk("t2_wen_cnt", 32'(wen_cnt - w0), 32'h1);

        // Contention straight out of reset: m0 first, m1 from RESP.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t3_rdata_rst", m1_rdata, 32'h0);
        set_m0(1'b0, 18'h10, 32'h0, MASK_W);
        set_m1(1'b0, 18'h14, 32'h0, MASK_W);
        #1 chk("t3_gnt_a", 32'({m1_gnt, m0_gnt}), 32'h1);
        step();
        m0_req = 1'b0;
        #1 chk("t3_gnt_access", 32'({m1_gnt, m0_gnt}), 32'h0);
        step();
        chk("t3_m0_done",  32'({m1_done, m0_done}), 32'h1);
        chk("t3_m0_rdata", m0_rdata, 32'hAB22_3344);
        #1 chk("t3_gnt_b", 32'({m1_gnt, m0_gnt}), 32'h2);
        step();
        m1_req = 1'b0;
        step();
        chk("t3_m1_done",  32'({m1_done, m0_done}), 32'h2);
        chk("t3_m1_rdata", m1_rdata, 32'h5566_7788);
        step();

        // Continuous contention: eight grants alternating, one every 2 cycles.
        set_m0(1'b0, 18'h10, 32'h0, MASK_W);
        set_m1(1'b0, 18'h14, 32'h0, MASK_W);
        p0 = 1'b0; p1 = 1'b0; ngnt = 0;
        for (int c = 0; c < 16; c++) begin
            if (p0) m0_req = 1'b0;
            if (p1) m1_req = 1'b0;
            if (m0_done) m0_req = 1'b1;
            if (m1_done) m1_req = 1'b1;
            #1;
            exp_g = (c % 2 == 1) ? 2'b00 : (((c / 2) % 2 == 1) ? 2'b10 : 2'b01);
            chk($sformatf("t4_gnt_c%0d", c), 32'({m1_gnt, m0_gnt}), 32'(exp_g));
            if (m0_gnt || m1_gnt) ngnt++;
            p0 = m0_gnt; p1 = m1_gnt;
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("t4_ngnt",     32'(ngnt), 32'd8);
        chk("t4_last_done", 32'({m1_done, m0_done}), 32'h2);
        chk("t4_m1_rdata", m1_rdata, 32'h5566_7788);
        step();

        // Half and byte loads from the restored word.
        preload(6'd4, 32'h1122_3344);
        set_m0(1'b0, 18'h12, 32'h0, MASK_H);
        #1 chk("t5_gnt", 32'(m0_gnt), 32'h1);
        step();
        m0_req = 1'b0;
        step();
        chk("t5_done",  32'(m0_done), 32'h1);
        chk("t5_half",  m0_rdata, 32'h0000_1122);
        set_m1(1'b0, 18'h13, 32'h0, MASK_B);
        #1 chk("t5_gnt_b", 32'(m1_gnt), 32'h1);
        step();
        m1_req = 1'b0;
        step();
        chk("t5_byte", m1_rdata, 32'h0000_0011);
        step();

        // Reset during the ACCESS cycle of a store.
        set_m0(1'b1, 18'h18, 32'hDEAD_BEEF, MASK_W);
        #1 chk("t6_gnt", 32'(m0_gnt), 32'h1);
        step();
        m0_req = 1'b0;
        chk("t6_wen_on", 32'(dram_wen), 32'h1);
        #2 rst = 1'b1;
        #1 chk("t6_wen_off", 32'(dram_wen), 32'h0);
        chk("t6_paddr", 32'(perip_addr), 32'h0);
        chk("t6_pwdata", perip_wdata, 32'h0);
        set_m0(1'b0, 18'h10, 32'h0, MASK_W);
        #1 chk("t6_gnt_rst", 32'({m1_gnt, m0_gnt}), 32'h0);
        m0_req = 1'b0;
        w0 = wen_cnt;
        step();
        step();
        chk("t6_no_done", 32'({m1_done, m0_done}), 32'h0);
        chk("t6_rdata0",  m0_rdata, 32'h0);
        chk("t6_no_wen",  32'(wen_cnt - w0), 32'h0);
        rst = 1'b0;
        set_m1(1'b0, 18'h10, 32'h0, MASK_W);
        #1 chk("t6_post_gnt", 32'({m1_gnt, m0_gnt}), 32'h2);
        step();
        m1_req = 1'b0;
        step();
        chk("t6_post_done",  32'({m1_done, m0_done}), 32'h2);
        chk("t6_post_rdata", m1_rdata, 32'h1122_3344);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
